vc_credit_tracker: RTL and testbench

//  Per-VC status and credit bookkeeping for the NIC output port.

---
 rtl/vc_credit_if.sv | 26 ++
 rtl/vc_credit_tracker.sv | 125 ++++++++++++
 tb/tb_vc_credit_tracker.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_credit_if.sv
// Handshake bundle between the VC allocator / flit sender side and the per-VC credit tracker.
// The master drives grants, sent flits and credit returns; the slave reports VC status.
interface vc_credit_if #(
    parameter int N_OF_REQUEST = 4,
    parameter int N_OF_VC      = 2
);
    logic [N_OF_REQUEST-1:0]         g_va_vn_i;
    logic [N_OF_REQUEST*N_OF_VC-1:0] g_vc_i;
    logic                            flit_valid_i;
    logic [N_OF_VC-1:0]              flit_vc_i;
    logic                            flit_tail_i;
    logic [N_OF_VC-1:0]              credit_i;
    logic [N_OF_VC-1:0]              vc_free_o;
    logic [N_OF_VC-1:0]              credit_avail_o;
    logic                            error_o;

    modport master (
        output g_va_vn_i, g_vc_i, flit_valid_i, flit_vc_i, flit_tail_i, credit_i,
        input  vc_free_o, credit_avail_o, error_o
    );

    modport slave (
        input  g_va_vn_i, g_vc_i, flit_valid_i, flit_vc_i, flit_tail_i, credit_i,
        output vc_free_o, credit_avail_o, error_o
    );
endinterface

// File: rtl/vc_credit_tracker.sv
// Per-VC lifecycle (FREE -> ALLOC -> DRAIN -> FREE) and downstream credit bookkeeping
// for the NIC output port; one lane instance per VC plus a sticky protocol-error flag.
module vc_credit_lane #(
    parameter int BUFFER_DEPTH  = 4,
    parameter int N_BITS_CREDIT = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic alloc_i,
    input  logic send_i,
    input  logic tail_i,
    input  logic credit_i,
    output logic vc_free_o,
    output logic credit_avail_o,
    output logic err_o
);
    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [N_BITS_CREDIT-1:0] FULL = N_BITS_CREDIT'(BUFFER_DEPTH);

    state_e                   state_q, state_d;
    logic [N_BITS_CREDIT-1:0] credit_q, credit_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FREE;
            credit_q <= FULL;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
        end
    end

    assign vc_free_o      = (state_q == ST_FREE) && (credit_q == FULL);
    assign credit_avail_o = (state_q == ST_ALLOC) && (credit_q != '0);

    always_comb begin
        // Send and return on the same cycle cancel; otherwise saturate at the ends.
        credit_d = credit_q;
        if (send_i && !credit_i)
            credit_d = (credit_q == '0) ? credit_q : credit_q - 1'b1;
        else if (credit_i && !send_i)
            credit_d = (credit_q == FULL) ? credit_q : credit_q + 1'b1;

        state_d = state_q;
        case (state_q)
            ST_FREE:  if (alloc_i) state_d = ST_ALLOC;
            // Tail whose credits already net to full skips DRAIN entirely.
            ST_ALLOC: if (send_i && tail_i) state_d = (credit_d == FULL) ? ST_FREE : ST_DRAIN;
            ST_DRAIN: if (credit_d == FULL) state_d = ST_FREE;
            default:  state_d = ST_FREE;
        endcase

        err_o = (alloc_i && !vc_free_o)
             || (send_i && (state_q != ST_ALLOC))
             || (send_i && (credit_q == '0) && !credit_i)
             || (credit_i && (credit_q == FULL) && !send_i);
    end
endmodule

module vc_credit_tracker #(
    parameter int N_OF_REQUEST  = 4,
    parameter int N_OF_VC       = 2,
    parameter int BUFFER_DEPTH  = 4,
    parameter int N_BITS_CREDIT = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic       clk,
    input  logic       rst,
    vc_credit_if.slave bus
);
    logic [N_OF_VC-1:0] alloc, alloc_dup, send;
    logic [N_OF_VC-1:0] vc_free, credit_avail, lane_err;
    logic               onehot_err;
    logic               error_q, error_d;

    always_comb begin
        alloc     = '0;
        alloc_dup = '0;
        for (int k = 0; k < N_OF_REQUEST; k++) begin
            for (int v = 0; v < N_OF_VC; v++) begin
                if (bus.g_va_vn_i[k] && bus.g_vc_i[k*N_OF_VC+v]) begin
                    if (alloc[v]) alloc_dup[v] = 1'b1;
                    alloc[v] = 1'b1;
                end
            end
        end
    end

    assign send       = {N_OF_VC{bus.flit_valid_i}} & bus.flit_vc_i;
    assign onehot_err = bus.flit_valid_i && !$onehot(bus.flit_vc_i);

    for (genvar v = 0; v < N_OF_VC; v++) begin : g_lane
        vc_credit_lane #(
            .BUFFER_DEPTH (BUFFER_DEPTH),
            .N_BITS_CREDIT(N_BITS_CREDIT)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .alloc_i       (alloc[v]),
            .send_i        (send[v]),
            .tail_i        (bus.flit_tail_i),
            .credit_i      (bus.credit_i[v]),
            .vc_free_o     (vc_free[v]),
            .credit_avail_o(credit_avail[v]),
            .err_o         (lane_err[v])
        );
    end

    always_comb begin
        error_d = error_q || (|lane_err) || (|alloc_dup) || onehot_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) error_q <= 1'b0;
        else     error_q <= error_d;
    end

    assign bus.vc_free_o      = vc_free;
    assign bus.credit_avail_o = credit_avail;
    assign bus.error_o        = error_q;
endmodule

// File: tb/tb_vc_credit_tracker.sv
// Directed scenarios plus randomized traffic, checked every cycle against an
// occupancy-based model of each VC (packet-open / draining flags and slots in use downstream).
module tb_vc_credit_tracker;
    localparam int NR = 4, NV = 2, DEPTH = 4;

    logic clk = 1'b0, rst = 1'b0;
    int n_checks = 0, n_errors = 0;

    vc_credit_if #(.N_OF_REQUEST(NR), .N_OF_VC(NV)) bus ();
    vc_credit_tracker #(.N_OF_REQUEST(NR), .N_OF_VC(NV), .BUFFER_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: outst = flits sitting in the downstream buffer, in_pkt = VC owns an open packet,
    // drain = packet finished but slots still occupied.
    int outst[NV];
    bit in_pkt[NV];
    bit drain[NV];
    bit m_err;

    function automatic bit m_free(int v);
        return !in_pkt[v] && !drain[v] && (outst[v] == 0);
    endfunction

    function automatic bit m_avail(int v);
        return in_pkt[v] && (outst[v] < DEPTH);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NV; v++) begin
                outst[v] = 0; in_pkt[v] = 0; drain[v] = 0;
            end
            m_err = 0;
        end else begin
            if (bus.flit_valid_i && ($countones(bus.flit_vc_i) != 1)) m_err = 1;
            for (int v = 0; v < NV; v++) begin
                int grants, nxt;
                bit snd, cr;
                grants = 0;
                for (int k = 0; k < NR; k++)
                    if (bus.g_va_vn_i[k] && bus.g_vc_i[k*NV+v]) grants++;
                snd = bus.flit_valid_i && bus.flit_vc_i[v];
                cr  = bus.credit_i[v];
                if (grants > 1) m_err = 1;
                if (grants > 0 && !m_free(v)) m_err = 1;
                if (snd && !in_pkt[v]) m_err = 1;
                if (snd && !cr && outst[v] == DEPTH) m_err = 1;
                if (cr && !snd && outst[v] == 0) m_err = 1;
                nxt = outst[v] + int'(snd) - int'(cr);
                if (nxt < 0) nxt = 0;
                if (nxt > DEPTH) nxt = DEPTH;
                if (in_pkt[v]) begin
                    if (snd && bus.flit_tail_i) begin
                        in_pkt[v] = 0;
                        drain[v]  = (nxt != 0);
                    end
                end else if (drain[v]) begin
                    if (nxt == 0) drain[v] = 0;
                end else if (grants > 0) begin
                    in_pkt[v] = 1;
                end
                outst[v] = nxt;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            logic [NV-1:0] ef, ea;
            for (int v = 0; v < NV; v++) begin
                ef[v] = m_free(v);
                ea[v] = m_avail(v);
            end
            check("model_vc_free", 32'(bus.vc_free_o), 32'(ef));
            check("model_credit_avail", 32'(bus.credit_avail_o), 32'(ea));
            check("model_error", 32'(bus.error_o), 32'(m_err));
        end
    end

    task automatic clear_in();
        bus.g_va_vn_i    = '0;
        bus.g_vc_i       = '0;
        bus.flit_valid_i = 1'b0;
        bus.flit_vc_i    = '0;
        bus.flit_tail_i  = 1'b0;
        bus.credit_i     = '0;
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic grant(int k, int v);
        bus.g_va_vn_i[k]     = 1'b1;
        bus.g_vc_i[k*NV + v] = 1'b1;
    endtask

    task automatic do_reset();
        clear_in();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(logic [NV-1:0] vc, logic tail);
        bus.flit_valid_i = 1'b1;
        bus.flit_vc_i    = vc;
        bus.flit_tail_i  = tail;
    endtask

    task automatic rand_cycle(bit noisy);
        int sv;
        for (int v = 0; v < NV; v++)
            if (m_free(v) && $urandom_range(0, 2) == 0) grant($urandom_range(0, NR-1), v);
        sv = $urandom_range(0, NV-1);
        if (m_avail(sv) && $urandom_range(0, 1) == 1) begin
            bus.flit_valid_i   = 1'b1;
            bus.flit_vc_i[sv]  = 1'b1;
            bus.flit_tail_i    = ($urandom_range(0, 3) == 0);
        end
        for (int v = 0; v < NV; v++)
            if (outst[v] > 0 && $urandom_range(0, 2) == 0) bus.credit_i[v] = 1'b1;
        if (noisy && $urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 3))
                0: begin
                    bus.g_va_vn_i = NR'($urandom);
                    bus.g_vc_i    = (NR*NV)'($urandom);
                end
                1: begin
                    bus.flit_valid_i = 1'b1;
                    bus.flit_vc_i    = NV'($urandom);
                end
                2: bus.credit_i = NV'($urandom);
                default: begin
                    bus.flit_valid_i = 1'b1;
                    bus.flit_tail_i  = 1'b1;
                    bus.flit_vc_i    = '0;
                    bus.flit_vc_i[$urandom_range(0, NV-1)] = 1'b1;
                end
            endcase
        end
    endtask

    initial begin
        clear_in();
        #1 rst = 1'b1;
        #1;
        check("rst_vc_free", 32'(bus.vc_free_o), 32'h3);
        check("rst_credit_avail", 32'(bus.credit_avail_o), 32'h0);
        check("rst_error", 32'(bus.error_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        check("idle_vc_free", 32'(bus.vc_free_o), 32'h3);
        check("idle_credit_avail", 32'(bus.credit_avail_o), 32'h0);

        // Grant req2 -> VC1
        grant(2, 1); tick(); clear_in();
        check("grant_vc_free", 32'(bus.vc_free_o), 32'h1);
        check("grant_credit_avail", 32'(bus.credit_avail_o), 32'h2);

        // Drain all four credits on VC1, then overrun
        send(2'b10, 1'b0); tick(3);
        check("send3_avail", 32'(bus.credit_avail_o), 32'h2);
        tick();
        check("send4_avail", 32'(bus.credit_avail_o), 32'h0);
        check("send4_error", 32'(bus.error_o), 32'h0);
        tick(); clear_in();
        check("send5_error", 32'(bus.error_o), 32'h1);
        tick(2);
        check("error_sticky", 32'(bus.error_o), 32'h1);

        // 3-flit packet on VC1, then credits trickle back
        do_reset();
        grant(0, 1); tick(); clear_in();
        send(2'b10, 1'b0); tick(2);
        bus.flit_tail_i = 1'b1; tick(); clear_in();
        check("drain_vc_free", 32'(bus.vc_free_o), 32'h1);
        check("drain_credit_avail", 32'(bus.credit_avail_o), 32'h0);
        bus.credit_i = 2'b10; tick();
        check("credit1_vc_free", 32'(bus.vc_free_o), 32'h1);
        tick();
        check("credit2_vc_free", 32'(bus.vc_free_o), 32'h1);
        tick(); clear_in();
        check("credit3_vc_free", 32'(bus.vc_free_o), 32'h3);
        check("credit3_error", 32'(bus.error_o), 32'h0);

        // Single-flit packet on VC0 with same-cycle credit return
        grant(1, 0); tick(); clear_in();
        check("sf_grant_vc_free", 32'(bus.vc_free_o), 32'h2);
        check("sf_grant_avail", 32'(bus.credit_avail_o), 32'h1);
        send(2'b01, 1'b1); bus.credit_i = 2'b01; tick(); clear_in();
        check("sf_vc_free", 32'(bus.vc_free_o), 32'h3);
        check("sf_credit_avail", 32'(bus.credit_avail_o), 32'h0);
        check("sf_error", 32'(bus.error_o), 32'h0);

        // Error cases and mid-packet reset
        grant(0, 0); grant(3, 0); tick(); clear_in();
        check("dup_grant_error", 32'(bus.error_o), 32'h1);
        do_reset();
        check("after_rst_error", 32'(bus.error_o), 32'h0);
        bus.credit_i = 2'b10; tick(); clear_in();
        check("overflow_error", 32'(bus.error_o), 32'h1);
        do_reset();
        grant(0, 0); tick(); clear_in();
        send(2'b01, 1'b0); tick(); clear_in();
        check("midpkt_vc_free", 32'(bus.vc_free_o), 32'h2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_vc_free", 32'(bus.vc_free_o), 32'h3);
        check("async_rst_avail", 32'(bus.credit_avail_o), 32'h0);
        check("async_rst_error", 32'(bus.error_o), 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int ep = 0; ep < 24; ep++) begin
            bit noisy;
            noisy = (ep % 3 == 2);
            do_reset();
            for (int c = 0; c < 80; c++) begin
                clear_in();
                rand_cycle(noisy);
                tick();
            end
        end

        clear_in();
        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
